// File: rtl/baccarat_deal_fsm.sv
// Deal sequencer for the Baccarat card datapath: orders the card-register loads,
// applies the third-card drawing rules and registers the win lights.
module baccarat_deal_fsm #(
  parameter bit          RESTART_EN    = 1'b0,
  parameter int unsigned RESTART_DELAY = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       new_hand,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam int CW = (RESTART_DELAY > 1) ? $clog2(RESTART_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RESTART_DELAY - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    P1    = 4'd1,
    D1    = 4'd2,
    P2    = 4'd3,
    D2    = 4'd4,
    EVAL  = 4'd5,
    P3    = 4'd6,
    EVAL3 = 4'd7,
    D3    = 4'd8,
    SCORE = 4'd9,
    DONE  = 4'd10,
    CLR   = 4'd11
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic          load_pcard1_r, load_pcard2_r, load_pcard3_r;
  logic          load_dcard1_r, load_dcard2_r, load_dcard3_r;
  logic          new_hand_r, player_win_r, dealer_win_r;

  // Dealer third-card rule; face cards and tens count as zero, illegal scores never draw.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] rank);
    logic [3:0] v;
    v = (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
    case (ds)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (v != 4'd8);
      4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  endfunction

  // Next-state decode for the deal sequence.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:  state_next_s = P1;
      P1:    state_next_s = D1;
      D1:    state_next_s = P2;
      P2:    state_next_s = D2;
      D2:    state_next_s = EVAL;
      EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) begin
          state_next_s = SCORE;
        end else if (pscore <= 4'd5) begin
          state_next_s = P3;
        end else if (dscore <= 4'd5) begin
          state_next_s = D3;
        end else begin
          state_next_s = SCORE;
        end
      end
      P3:    state_next_s = EVAL3;
      EVAL3: begin
        if (dealer_draws(dscore, pcard3)) begin
          state_next_s = D3;
        end else begin
          state_next_s = SCORE;
        end
      end
      D3:    state_next_s = SCORE;
      SCORE: state_next_s = DONE;
      DONE: begin
        if (RESTART_EN && (cnt_r == CNT_LAST)) begin
          state_next_s = CLR;
        end else begin
          state_next_s = DONE;
        end
      end
      CLR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, restart counter and outputs; strobes are decoded from the next state so they
  // line up with the state they belong to while still coming straight from flops.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      load_pcard1_r <= 1'b0;
      load_pcard2_r <= 1'b0;
      load_pcard3_r <= 1'b0;
      load_dcard1_r <= 1'b0;
      load_dcard2_r <= 1'b0;
      load_dcard3_r <= 1'b0;
      new_hand_r    <= 1'b0;
      player_win_r  <= 1'b0;
      dealer_win_r  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      load_pcard1_r <= (state_next_s == P1);
      load_dcard1_r <= (state_next_s == D1);
      load_pcard2_r <= (state_next_s == P2);
      load_dcard2_r <= (state_next_s == D2);
      load_pcard3_r <= (state_next_s == P3);
      load_dcard3_r <= (state_next_s == D3);
      new_hand_r    <= (state_next_s == CLR);

      // A tie lights both lamps, hence the inclusive compares.
      if (state_r == SCORE) begin
        player_win_r <= (pscore >= dscore);
        dealer_win_r <= (dscore >= pscore);
      end else if (state_next_s == CLR) begin
        player_win_r <= 1'b0;
        dealer_win_r <= 1'b0;
      end else begin
        player_win_r <= player_win_r;
        dealer_win_r <= dealer_win_r;
      end

      if (RESTART_EN && (state_r == DONE)) begin
        cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign load_pcard1      = load_pcard1_r;
  assign load_pcard2      = load_pcard2_r;
  assign load_pcard3      = load_pcard3_r;
  assign load_dcard1      = load_dcard1_r;
  assign load_dcard2      = load_dcard2_r;
  assign load_dcard3      = load_dcard3_r;
  assign new_hand         = new_hand_r;
  assign player_win_light = player_win_r;
  assign dealer_win_light = dealer_win_r;

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed bench for baccarat_deal_fsm: a hold-result instance and an auto-restart instance
// (delay 3) share the score inputs; the unused one is kept in reset.
module tb_baccarat_deal_fsm;

  localparam logic [6:0] S_0  = 7'b0000000;
  localparam logic [6:0] S_P1 = 7'b1000000;
  localparam logic [6:0] S_D1 = 7'b0100000;
  localparam logic [6:0] S_P2 = 7'b0010000;
  localparam logic [6:0] S_D2 = 7'b0001000;
  localparam logic [6:0] S_P3 = 7'b0000100;
  localparam logic [6:0] S_D3 = 7'b0000010;
  localparam logic [6:0] S_NH = 7'b0000001;

  logic       clk = 1'b0;
  logic       rstb_a = 1'b1;
  logic       rstb_b = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;

  logic a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_nh, a_pw, a_dw;
  logic b_p1, b_p2, b_p3, b_d1, b_d2, b_d3, b_nh, b_pw, b_dw;
  logic [6:0] sa, sb;
  logic [1:0] la, lb;

  int n_checks = 0;
  int n_fail   = 0;

  assign sa = {a_p1, a_d1, a_p2, a_d2, a_p3, a_d3, a_nh};
  assign sb = {b_p1, b_d1, b_p2, b_d2, b_p3, b_d3, b_nh};
  assign la = {a_pw, a_dw};
  assign lb = {b_pw, b_dw};

  always #5 clk = ~clk;

  baccarat_deal_fsm #(.RESTART_EN(1'b0), .RESTART_DELAY(8)) dut_a (
    .slow_clock(clk), .resetb(rstb_a), .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(a_p1), .load_pcard2(a_p2), .load_pcard3(a_p3),
    .load_dcard1(a_d1), .load_dcard2(a_d2), .load_dcard3(a_d3),
    .new_hand(a_nh), .player_win_light(a_pw), .dealer_win_light(a_dw));

  baccarat_deal_fsm #(.RESTART_EN(1'b1), .RESTART_DELAY(3)) dut_b (
    .slow_clock(clk), .resetb(rstb_b), .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(b_p1), .load_pcard2(b_p2), .load_pcard3(b_p3),
    .load_dcard1(b_d1), .load_dcard2(b_d2), .load_dcard3(b_d3),
    .new_hand(b_nh), .player_win_light(b_pw), .dealer_win_light(b_dw));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds dut_a in reset for one edge, loads the scores, releases just after an edge.
  task automatic start_a(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] c3);
    rstb_a = 1'b0;
    step();
    pscore = ps;
    dscore = ds;
    pcard3 = c3;
    rstb_a = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rstb_a = 1'b0;
    rstb_b = 1'b0;
    #1;
    n_checks++;
    if ({sa, la, sb, lb} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got a=%b/%b b=%b/%b want all 0", sa, la, sb, lb);
    end
    step();
    step();
    n_checks++;
    if ({sa, la, sb, lb} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_held got a=%b/%b b=%b/%b want all 0", sa, la, sb, lb);
    end
  endtask

  task automatic test_natural_hold();
    logic [6:0] exp_seq [0:6];
    exp_seq = '{S_P1, S_D1, S_P2, S_D2, S_0, S_0, S_0};
    start_a(4'd8, 4'd3, 4'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (sa !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL natural_strobe E%0d got %b want %b", i + 1, sa, exp_seq[i]);
      end
      if (i == 5) begin
        n_checks++;
        if (la !== 2'b00) begin
          n_fail++;
          $display("FAIL natural_lights_early got %b want 00", la);
        end
      end
    end
    n_checks++;
    if (la !== 2'b10) begin
      n_fail++;
      $display("FAIL natural_lights got %b want 10", la);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({sa, la} !== {S_0, 2'b10}) begin
        n_fail++;
        $display("FAIL natural_hold cycle %0d got %b/%b want 0000000/10", i, sa, la);
      end
    end
  endtask

  task automatic test_both_draw();
    logic [6:0] exp_seq [0:9];
    exp_seq = '{S_P1, S_D1, S_P2, S_D2, S_0, S_P3, S_0, S_D3, S_0, S_0};
    start_a(4'd4, 4'd3, 4'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (sa !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL both_draw_strobe E%0d got %b want %b", i + 1, sa, exp_seq[i]);
      end
      if (i == 7) begin
        pscore = 4'd8;
        dscore = 4'd9;
      end
      if (i == 8) begin
        n_checks++;
        if (la !== 2'b00) begin
          n_fail++;
          $display("FAIL both_draw_lights_early got %b want 00", la);
        end
      end
    end
    n_checks++;
    if (la !== 2'b01) begin
      n_fail++;
      $display("FAIL both_draw_lights got %b want 01", la);
    end
  endtask

  task automatic test_dealer_rules();
    // {dscore at EVAL, dscore at EVAL3, pcard3 rank, dealer draws}
    logic [12:0] tbl [0:11];
    tbl = '{{4'd6, 4'd6, 4'd7, 1'b1}, {4'd6, 4'd6, 4'd8, 1'b0},
            {4'd3, 4'd3, 4'd8, 1'b0}, {4'd3, 4'd3, 4'd12, 1'b1},
            {4'd4, 4'd4, 4'd1, 1'b0}, {4'd4, 4'd4, 4'd2, 1'b1},
            {4'd5, 4'd5, 4'd3, 1'b0}, {4'd5, 4'd5, 4'd7, 1'b1},
            {4'd0, 4'd0, 4'd10, 1'b1}, {4'd7, 4'd7, 4'd6, 1'b0},
            {4'd6, 4'd6, 4'd13, 1'b0}, {4'd2, 4'd11, 4'd5, 1'b0}};
    for (int k = 0; k < 12; k++) begin
      start_a(4'd2, tbl[k][12:9], tbl[k][4:1]);
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if (sa !== S_P3) begin
        n_fail++;
        $display("FAIL rule%0d_p3 got %b want %b", k, sa, S_P3);
      end
      dscore = tbl[k][8:5];
      step();
      step();
      n_checks++;
      if (sa !== (tbl[k][0] ? S_D3 : S_0)) begin
        n_fail++;
        $display("FAIL rule%0d_d3 ds=%0d rank=%0d got %b want %b", k, tbl[k][8:5],
                 tbl[k][4:1], sa, tbl[k][0] ? S_D3 : S_0);
      end
    end
  endtask

  task automatic test_player_stands();
    // {pscore, dscore at EVAL, dscore after D3, D3 expected, final lights}
    logic [14:0] tbl [0:2];
    int n;
    tbl = '{{4'd7, 4'd5, 4'd7, 1'b1, 2'b11},
            {4'd6, 4'd6, 4'd6, 1'b0, 2'b11},
            {4'd12, 4'd0, 4'd0, 1'b0, 2'b10}};
    for (int k = 0; k < 3; k++) begin
      start_a(tbl[k][14:11], tbl[k][10:7], 4'd0);
      n = tbl[k][2] ? 8 : 7;
      for (int i = 0; i < 5; i++) step();
      step();
      n_checks++;
      if (sa !== (tbl[k][2] ? S_D3 : S_0)) begin
        n_fail++;
        $display("FAIL stand%0d_e6 got %b want %b", k, sa, tbl[k][2] ? S_D3 : S_0);
      end
      dscore = tbl[k][6:3];
      for (int i = 7; i < n; i++) step();
      n_checks++;
      if (la !== 2'b00) begin
        n_fail++;
        $display("FAIL stand%0d_lights_early got %b want 00", k, la);
      end
      step();
      n_checks++;
      if ({sa, la} !== {S_0, tbl[k][1:0]}) begin
        n_fail++;
        $display("FAIL stand%0d_lights got %b/%b want 0000000/%b", k, sa, la, tbl[k][1:0]);
      end
    end
  endtask

  task automatic test_auto_restart();
    logic [8:0] exp_seq [0:11];
    exp_seq = '{{S_P1, 2'b00}, {S_D1, 2'b00}, {S_P2, 2'b00}, {S_D2, 2'b00},
                {S_0, 2'b00}, {S_0, 2'b00}, {S_0, 2'b10}, {S_0, 2'b10},
                {S_0, 2'b10}, {S_NH, 2'b00}, {S_0, 2'b00}, {S_P1, 2'b00}};
    rstb_a = 1'b0;
    rstb_b = 1'b0;
    step();
    pscore = 4'd9;
    dscore = 4'd0;
    pcard3 = 4'd0;
    rstb_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if ({sb, lb} !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL restart E%0d got %b/%b want %b/%b", i + 1, sb, lb,
                 exp_seq[i][8:2], exp_seq[i][1:0]);
      end
    end
    rstb_b = 1'b0;
  endtask

  task automatic test_async_reset();
    start_a(4'd3, 4'd3, 4'd0);
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (sa !== S_P3) begin
      n_fail++;
      $display("FAIL async_in_p3 got %b want %b", sa, S_P3);
    end
    #2;
    rstb_a = 1'b0;
    #1;
    n_checks++;
    if ({sa, la} !== 9'd0) begin
      n_fail++;
      $display("FAIL async_drop_p3 got %b/%b want all 0", sa, la);
    end
    step();
    rstb_a = 1'b1;
    #1;
    n_checks++;
    if (sa !== S_0) begin
      n_fail++;
      $display("FAIL async_idle got %b want 0000000", sa);
    end
    step();
    n_checks++;
    if (sa !== S_P1) begin
      n_fail++;
      $display("FAIL async_restart_p1 got %b want %b", sa, S_P1);
    end
    pscore = 4'd9;
    dscore = 4'd0;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (la !== 2'b10) begin
      n_fail++;
      $display("FAIL async_done_lights got %b want 10", la);
    end
    #2;
    rstb_a = 1'b0;
    #1;
    n_checks++;
    if (la !== 2'b00) begin
      n_fail++;
      $display("FAIL async_clear_lights got %b want 00", la);
    end
    rstb_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_natural_hold();
    test_both_draw();
    test_dealer_rules();
    test_player_stands();
    test_auto_restart();
    test_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
